fdiv_arbiter: RTL

- Shares one iterative Newton floating-point divider (16-cycle iteration core plus result pipeline) among NREQ requesters.
- Arbitrates round-robin and latches the winner's operands.
- Holds the operands stable at the divider for the whole operation and drives the single-cycle fdiv start pulse.
- Counts the fixed divider latency, then returns the quotient with the requester id over a valid/ready response channel.

---
 rtl/fdiv_arbiter_if.sv | 26 ++
 rtl/fdiv_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fdiv_arbiter_if.sv
// Requester/consumer bundle for fdiv_arbiter: per-requester operands in, tagged quotient out.
// master = requesters and response consumer; slave = the arbiter.
interface fdiv_arbiter_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    logic [NREQ-1:0]      req;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [2*NREQ-1:0]    req_rm;
    logic [NREQ-1:0]      req_ack;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_s;

    modport master (
        output req, req_a, req_b, req_rm, rsp_ready,
        input  req_ack, rsp_valid, rsp_id, rsp_s
    );

    modport slave (
        input  req, req_a, req_b, req_rm, rsp_ready,
        output req_ack, rsp_valid, rsp_id, rsp_s
    );
endinterface

// File: rtl/fdiv_arbiter.sv
// Round-robin sharing of one fixed-latency floating-point divider among NREQ requesters.
// Define FDIV_ARB_STATS_EN to add the stat_ops / stat_stall counters.
module fdiv_arbiter #(
    parameter int NREQ    = 2,
    parameter int IDW     = 1,
    parameter int DIV_LAT = 18
) (
    input  logic        clock,
    input  logic        reset,
    fdiv_arbiter_if.slave bus,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic [1:0]  div_rm,
    output logic        div_fdiv,
    output logic        div_enable,
    input  logic        div_busy,
    input  logic [31:0] div_s,
    output logic        idle
`ifdef FDIV_ARB_STATS_EN
    ,
    output logic [31:0] stat_ops,
    output logic [31:0] stat_stall
`endif
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(DIV_LAT + 1);

    logic [1:0]    state_reg, state_next;
    logic [SW-1:0] last_grant_reg;
    logic [CW-1:0] count_reg;
    logic [IDW-1:0] rsp_id_reg;
    logic [31:0]   rsp_s_reg;
    logic [31:0]   div_a_reg, div_b_reg;
    logic [1:0]    div_rm_reg;

    logic [31:0]   a_arr   [NREQ];
    logic [31:0]   b_arr   [NREQ];
    logic [1:0]    rm_arr  [NREQ];
    logic [SW-1:0] rot_idx [NREQ];
    logic [SW-1:0] winner;
    logic          grant;

    // rot_idx[k] is the requester examined k-th, starting just after the last winner.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign a_arr[gi]       = bus.req_a[32*gi +: 32];
        assign b_arr[gi]       = bus.req_b[32*gi +: 32];
        assign rm_arr[gi]      = bus.req_rm[2*gi +: 2];
        assign rot_idx[gi]     = SW'((int'(last_grant_reg) + gi + 1) % NREQ);
        assign bus.req_ack[gi] = (state_reg == S_ISSUE) && (rsp_id_reg == IDW'(gi));
    end

    // Scan from the far end so the nearest set request is the one that sticks.
    always_comb begin
        winner = last_grant_reg;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[rot_idx[k]]) begin
                winner = rot_idx[k];
            end
        end
    end

    assign grant = (state_reg == S_IDLE) && (|bus.req) && !div_busy;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (grant) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (count_reg == CW'(1)) state_next = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            last_grant_reg <= SW'(NREQ - 1);
            count_reg      <= '0;
            rsp_id_reg     <= '0;
            rsp_s_reg      <= '0;
            div_a_reg      <= '0;
            div_b_reg      <= '0;
            div_rm_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                div_a_reg      <= a_arr[winner];
                div_b_reg      <= b_arr[winner];
                div_rm_reg     <= rm_arr[winner];
                rsp_id_reg     <= IDW'(winner);
                last_grant_reg <= winner;
            end
            if (state_reg == S_ISSUE) begin
                count_reg <= CW'(DIV_LAT);
            end else if (state_reg == S_WAIT) begin
                count_reg <= count_reg - CW'(1);
                // Divider result is valid in the final WAIT cycle only.
                if (count_reg == CW'(1)) begin
                    rsp_s_reg <= div_s;
                end
            end
        end
    end

`ifdef FDIV_ARB_STATS_EN
    logic [31:0] stat_ops_reg, stat_stall_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_ops_reg   <= '0;
            stat_stall_reg <= '0;
        end else begin
            if ((state_reg == S_RESP) && bus.rsp_ready) begin
                stat_ops_reg <= stat_ops_reg + 32'd1;
            end
            if ((state_reg == S_IDLE) && (|bus.req) && div_busy) begin
                stat_stall_reg <= stat_stall_reg + 32'd1;
            end
        end
    end

    assign stat_ops   = stat_ops_reg;
    assign stat_stall = stat_stall_reg;
`endif

    assign div_a         = div_a_reg;
    assign div_b         = div_b_reg;
    assign div_rm        = div_rm_reg;
    assign div_fdiv      = (state_reg == S_ISSUE);
    assign div_enable    = (state_reg == S_ISSUE) || (state_reg == S_WAIT);
    assign idle          = (state_reg == S_IDLE);
    assign bus.rsp_valid = (state_reg == S_RESP);
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_s     = rsp_s_reg;
endmodule
